// File: rtl/line_clock_timer.sv
// line_clock_timer: KW11-L style line-clock timer with Wishbone CSR.
// Divides wb_clk_i down to one of two tick rates and raises a latched EVNT irq.
//
// Ports:
//   wb_clk_i, wb_rst_i      bus clock, synchronous active-high reset
//   wb_cyc_i/stb_i/we_i     Wishbone CSR access (address decoded outside)
//   wb_sel_i, wb_dat_i      byte select and write data
//   wb_dat_o, wb_ack_o      read data (valid only during ack) and acknowledge
//   button_i                synchronised enable-toggle button
//   irq_ack_i               one-cycle interrupt acknowledge
//   tick_o                  one-cycle pulse per divider period
//   irq_o                   latched interrupt request (CPU EVNT)
//   timer_status_o          current ENABLE bit (status LED)
//
// CSR: [7] MON, [6] IE, [1] ENABLE, [0] RATE (0: RATE_HZ, 1: ALT_RATE_HZ).
// Optional macro LINE_CLOCK_TIMER_LOST_CNT_EN adds a saturating lost-tick
// counter in CSR[15:8], cleared by any write with wb_sel_i[1] set.

module line_clock_timer #(
    parameter int CLK_HZ      = 100000000,
    parameter int RATE_HZ     = 50,
    parameter int ALT_RATE_HZ = 60,
    parameter int DEB_BITS    = 2,
    parameter bit INIT_EN     = 1'b1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        button_i,
    input  logic        irq_ack_i,
    output logic        tick_o,
    output logic        irq_o,
    output logic        timer_status_o
);

    localparam int DIV0   = CLK_HZ / RATE_HZ;
    localparam int DIV1   = CLK_HZ / ALT_RATE_HZ;
    localparam int DIVMAX = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int CW     = (DIVMAX > 1) ? $clog2(DIVMAX) : 1;

    localparam logic [CW-1:0] LAST0 = CW'(DIV0 - 1);
    localparam logic [CW-1:0] LAST1 = CW'(DIV1 - 1);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic                tick_q, tick_d;
    logic                ack_q, ack_d;
    logic                ie_q, ie_d;
    logic                en_q, en_d;
    logic                rate_q, rate_d;
    logic                mon_q, mon_d;
    logic                irq_q, irq_d;
    logic [DEB_BITS-1:0] sh_q, sh_d;
    logic                latch_q, latch_d;

    logic                wr_lo;
    logic                wr_hi;
    logic                rate_chg;
    logic                tick_evt;
    logic [CW-1:0]       last;
    logic [7:0]          csr_hi;
    logic                unused;

    // Write commits in the ack cycle, while the master still holds the strobe.
    assign wr_lo = ack_q & wb_cyc_i & wb_stb_i & wb_we_i & wb_sel_i[0];
    assign wr_hi = ack_q & wb_cyc_i & wb_stb_i & wb_we_i & wb_sel_i[1];

    // Switching rate restarts the period and swallows a coincident tick.
    assign rate_chg = wr_lo & (wb_dat_i[0] != rate_q);
    assign last     = rate_q ? LAST1 : LAST0;
    assign tick_evt = ~rate_chg & (cnt_q == last);

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        tick_d  = tick_evt;
        ack_d   = wb_cyc_i & wb_stb_i & ~ack_q;
        ie_d    = ie_q;
        en_d    = en_q;
        rate_d  = rate_q;
        mon_d   = mon_q;
        irq_d   = irq_q;
        sh_d    = sh_q;
        latch_d = latch_q;

        if (rate_chg || tick_evt) begin
            cnt_d = '0;
        end

        // Button is debounced at tick rate; latch blocks repeat toggles
        // until the button has been seen fully released.
        if (tick_evt) begin
            sh_d = DEB_BITS'({sh_q, button_i});
            if ((&sh_d) && !latch_q) begin
                en_d    = ~en_q;
                latch_d = 1'b1;
            end else if (sh_d == '0) begin
                latch_d = 1'b0;
            end
        end

        // Applied after the button so a CSR write to ENABLE wins.
        if (wr_lo) begin
            ie_d   = wb_dat_i[6];
            en_d   = wb_dat_i[1];
            rate_d = wb_dat_i[0];
            if (!wb_dat_i[7]) begin
                mon_d = 1'b0;
            end
        end

        if (tick_evt) begin
            mon_d = 1'b1;
        end

        // Set beats acknowledge; dropping IE or ENABLE withdraws the request.
        if (irq_ack_i) begin
            irq_d = 1'b0;
        end
        if (!(ie_d && en_d)) begin
            irq_d = 1'b0;
        end
        if (tick_evt && ie_d && en_d) begin
            irq_d = 1'b1;
        end
    end

`ifdef LINE_CLOCK_TIMER_LOST_CNT_EN
    logic [7:0] lost_q, lost_d;

    always_comb begin
        lost_d = lost_q;
        if (wr_hi) begin
            lost_d = '0;
        end else if (tick_evt && irq_q && !irq_ack_i && (lost_q != 8'hFF)) begin
            lost_d = lost_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            lost_q <= '0;
        end else begin
            lost_q <= lost_d;
        end
    end

    assign csr_hi = lost_q;
`else
    assign csr_hi = 8'h00;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            ack_q   <= 1'b0;
            ie_q    <= 1'b0;
            en_q    <= INIT_EN;
            rate_q  <= 1'b0;
            mon_q   <= 1'b0;
            irq_q   <= 1'b0;
            sh_q    <= '0;
            latch_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            ack_q   <= ack_d;
            ie_q    <= ie_d;
            en_q    <= en_d;
            rate_q  <= rate_d;
            mon_q   <= mon_d;
            irq_q   <= irq_d;
            sh_q    <= sh_d;
            latch_q <= latch_d;
        end
    end

    assign wb_dat_o = ack_q ? {csr_hi, mon_q, ie_q, 4'b0000, en_q, rate_q}
                            : 16'h0000;
    assign wb_ack_o       = ack_q;
    assign tick_o         = tick_q;
    assign irq_o          = irq_q;
    assign timer_status_o = en_q;

    // Data bits with no CSR home, and the high-byte strobe in the base build.
    assign unused = ^{wb_dat_i[15:8], wb_dat_i[5:2], wr_hi};

endmodule

// File: tb/tb_line_clock_timer.sv
// tb_line_clock_timer: directed, table and random checks of line_clock_timer
// against an event-level reference model.

module tb_line_clock_timer;

    localparam int CLK_HZ  = 1200;
    localparam int RATE_HZ = 50;
    localparam int ALT_HZ  = 60;
    localparam int DEB     = 2;
    localparam int DIV0    = CLK_HZ / RATE_HZ;
    localparam int DIV1    = CLK_HZ / ALT_HZ;
`ifdef LINE_CLOCK_TIMER_LOST_CNT_EN
    localparam bit LOST_EN = 1'b1;
`else
    localparam bit LOST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [15:0] wdat = 16'h0;
    logic        btn = 1'b0;
    logic        iack = 1'b0;
    logic [15:0] dat_o;
    logic        ack_o;
    logic        tick_o;
    logic        irq_o;
    logic        stat_o;

    always #5 clk = ~clk;

    line_clock_timer #(
        .CLK_HZ(CLK_HZ),
        .RATE_HZ(RATE_HZ),
        .ALT_RATE_HZ(ALT_HZ),
        .DEB_BITS(DEB),
        .INIT_EN(1'b1)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wb_cyc_i(cyc),
        .wb_stb_i(stb),
        .wb_we_i(we),
        .wb_sel_i(sel),
        .wb_dat_i(wdat),
        .wb_dat_o(dat_o),
        .wb_ack_o(ack_o),
        .button_i(btn),
        .irq_ack_i(iack),
        .tick_o(tick_o),
        .irq_o(irq_o),
        .timer_status_o(stat_o)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: absolute edge numbers, next tick scheduled by edge.
    int m_edge = 0;
    int m_next = 0;
    int m_lost = 0;
    bit m_rate, m_ie, m_en, m_mon, m_irq, m_tick, m_ack, m_latch;
    bit hist[$];

    task automatic model_step();
        bit wr, wlo, whi, rchg, tk, en_n, ie_n, rate_n, all1, all0;
        m_edge++;
        if (rst) begin
            m_rate = 0; m_ie = 0; m_en = 1; m_mon = 0; m_irq = 0;
            m_tick = 0; m_ack = 0; m_latch = 0; m_lost = 0;
            hist.delete();
            repeat (DEB) hist.push_back(1'b0);
            m_next = m_edge + DIV0;
            return;
        end
        wr   = m_ack && cyc && stb && we;
        wlo  = wr && sel[0];
        whi  = wr && sel[1];
        rchg = wlo && (wdat[0] != m_rate);
        tk   = !rchg && (m_edge == m_next);
        en_n = m_en; ie_n = m_ie; rate_n = m_rate;
        if (tk) begin
            void'(hist.pop_front());
            hist.push_back(btn);
            all1 = 1; all0 = 1;
            foreach (hist[i]) begin
                if (hist[i]) all0 = 0;
                else all1 = 0;
            end
            if (all1 && !m_latch) begin
                en_n = !en_n;
                m_latch = 1;
            end else if (all0) begin
                m_latch = 0;
            end
        end
        if (wlo) begin
            ie_n = wdat[6]; en_n = wdat[1]; rate_n = wdat[0];
            if (!wdat[7]) m_mon = 0;
        end
        if (tk) m_mon = 1;
        if (whi) m_lost = 0;
        else if (tk && m_irq && !iack && m_lost < 255) m_lost++;
        if (iack) m_irq = 0;
        if (!(ie_n && en_n)) m_irq = 0;
        if (tk && ie_n && en_n) m_irq = 1;
        m_ie = ie_n; m_en = en_n;
        if (tk || rchg) m_next = m_edge + (rate_n ? DIV1 : DIV0);
        m_rate = rate_n;
        m_tick = tk;
        m_ack  = cyc && stb && !m_ack;
    endtask

    function automatic logic [19:0] exp_vec();
        logic [7:0]  hi;
        logic [15:0] csr;
        hi  = LOST_EN ? m_lost[7:0] : 8'h00;
        csr = {hi, m_mon, m_ie, 4'b0000, m_en, m_rate};
        return {m_tick, m_irq, m_en, m_ack, m_ack ? csr : 16'h0};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("cycle", {tick_o, irq_o, stat_o, ack_o, dat_o}, exp_vec());
    endtask

    task automatic bus(input bit w, input logic [1:0] s,
                       input logic [15:0] d, output logic [15:0] rd);
        cyc = 1; stb = 1; we = w; sel = s; wdat = d;
        step();
        check("ack_rise", ack_o, 1);
        rd = dat_o;
        step();
        check("ack_fall", ack_o, 0);
        check("dat_idle", dat_o, 0);
        cyc = 0; stb = 0; we = 0; sel = 0; wdat = 0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick_o && n < 200);
        if (!tick_o) check("tick_timeout", 0, 1);
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] wdat;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n;
        logic [15:0] rd;

        tbl[0] = '{2'b01, 16'h0041, 16'h0041};
        tbl[1] = '{2'b01, 16'h0043, 16'h0043};
        tbl[2] = '{2'b01, 16'h0002, 16'h0002};
        tbl[3] = '{2'b10, 16'hFFFF, 16'h0002};
        tbl[4] = '{2'b00, 16'h0041, 16'h0002};
        tbl[5] = '{2'b11, 16'h0001, 16'h0001};
        tbl[6] = '{2'b01, 16'h0040, 16'h0040};
        tbl[7] = '{2'b01, 16'hFFBF, 16'h0003};

        // Reset state and first CSR read.
        rst = 1;
        repeat (3) step();
        check("rst_status", stat_o, 1);
        check("rst_irq", irq_o, 0);
        check("rst_tick", tick_o, 0);
        rst = 0;
        bus(0, 2'b00, 16'h0, rd);
        check("rst_csr", rd, 16'h0002);

        // Primary rate: first tick and period.
        rst = 1;
        step();
        rst = 0;
        wait_tick(n);
        check("first_tick", n, DIV0);
        wait_tick(n);
        check("period0", n, DIV0);

        // Alternate rate restarts the divider; IE alone raises no irq.
        bus(1, 2'b01, 16'h0041, rd);
        wait_tick(n);
        check("restart_alt", n, DIV1);
        wait_tick(n);
        check("period1", n, DIV1);
        check("irq_no_en", irq_o, 0);
        bus(0, 2'b00, 16'h0, rd);
        check("mon_set", rd, 16'h00C1);

        bus(1, 2'b01, 16'h0043, rd);
        wait_tick(n);
        check("irq_rise", irq_o, 1);
        iack = 1;
        step();
        iack = 0;
        check("irq_ack", irq_o, 0);

        // Tick coinciding with acknowledge keeps the request.
        iack = 1;
        wait_tick(n);
        check("tick_vs_ack", irq_o, 1);
        iack = 0;
        step();
        check("irq_hold", irq_o, 1);
        bus(1, 2'b01, 16'h0003, rd);
        check("irq_ie_off", irq_o, 0);

        // Debounced button.
        btn = 1;
        wait_tick(n);
        check("deb_one", stat_o, 1);
        wait_tick(n);
        check("deb_toggle", stat_o, 0);
        repeat (10) wait_tick(n);
        check("deb_held", stat_o, 0);
        btn = 0;
        repeat (2) wait_tick(n);
        btn = 1;
        repeat (2) wait_tick(n);
        check("deb_again", stat_o, 1);
        btn = 0;

        // CSR write/read table.
        for (int i = 0; i < 8; i++) begin
            bus(1, tbl[i].sel, tbl[i].wdat, rd);
            bus(0, 2'b00, 16'h0, rd);
            check($sformatf("tbl%0d", i), rd & 16'h007F, tbl[i].exp);
        end

        // Lost-tick counter.
        bus(1, 2'b11, 16'hFF43, rd);
        repeat (5) wait_tick(n);
        bus(0, 2'b00, 16'h0, rd);
`ifdef LINE_CLOCK_TIMER_LOST_CNT_EN
        check("lost4", rd[15:8], 8'd4);
        repeat (300) wait_tick(n);
        bus(0, 2'b00, 16'h0, rd);
        check("lost_sat", rd[15:8], 8'd255);
        bus(1, 2'b10, 16'h0000, rd);
        bus(0, 2'b00, 16'h0, rd);
        check("lost_clr", rd[15:8], 8'd0);
`else
        check("hi_zero", rd[15:8], 8'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc  = ($urandom_range(0, 2) != 0);
            stb  = cyc && ($urandom_range(0, 3) != 0);
            we   = $urandom_range(0, 1);
            sel  = 2'($urandom_range(0, 3));
            wdat = 16'($urandom);
            wdat[0] = ($urandom_range(0, 15) == 0) ? ~m_rate : m_rate;
            if ($urandom_range(0, 29) == 0) btn = ~btn;
            iack = ($urandom_range(0, 9) == 0);
            rst  = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 0; cyc = 0; stb = 0; iack = 0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
